// File: rtl/free_list_n_pkg.sv
// Shared core package for the free list: default sizing, the tag type and a small helper.
package free_list_n_pkg;

    localparam int unsigned PRF_SIZE_DEF = 96;
    localparam int unsigned ARF_SIZE_DEF = 32;
    localparam int unsigned WAYS_DEF     = 2;
    localparam int unsigned TAG_W_DEF    = $clog2(PRF_SIZE_DEF);

    typedef logic [TAG_W_DEF-1:0] tag_t;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fl_ptr_add.sv
// Modular pointer add: sum = (ptr + n) mod ENTRIES, assuming n <= ENTRIES.
module fl_ptr_add #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned PTR_W   = 6,
    parameter int unsigned N_W     = 2
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic [N_W-1:0]   n,
    output logic [PTR_W-1:0] sum
);

    localparam int unsigned W = ((PTR_W > N_W) ? PTR_W : N_W) + 1;

    logic [W-1:0] wide;

    // A single conditional subtract suffices because both operands are below ENTRIES.
    always_comb begin
        wide = W'(ptr) + W'(n);
        if (wide >= W'(ENTRIES)) begin
            wide = wide - W'(ENTRIES);
        end
        sum = PTR_W'(wide);
    end

endmodule

// File: rtl/free_list_n.sv
// Circular free list of physical register tags with multi-way alloc/free,
// commit tracking and mispredict recovery of uncommitted allocations.
module free_list_n
    import free_list_n_pkg::*;
#(
    parameter int unsigned PRF_SIZE = PRF_SIZE_DEF,
    parameter int unsigned ARF_SIZE = ARF_SIZE_DEF,
    parameter int unsigned WAYS     = WAYS_DEF,
    localparam int unsigned TAG_W   = $clog2(PRF_SIZE),
    localparam int unsigned ENTRIES = PRF_SIZE - ARF_SIZE,
    localparam int unsigned NUM_W   = $clog2(WAYS + 1),
    localparam int unsigned CNT_W   = $clog2(ENTRIES + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_W-1:0]      alloc_num,
    input  logic [NUM_W-1:0]      free_num,
    input  logic [WAYS*TAG_W-1:0] free_tag,
    input  logic [NUM_W-1:0]      commit_num,
    input  logic                  recover,
    output logic [WAYS*TAG_W-1:0] alloc_tag,
    output logic [WAYS-1:0]       alloc_valid,
    output logic [CNT_W-1:0]      free_count,
    output logic                  error
);

    localparam int unsigned PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned SUM_W = CNT_W + 2;

    logic [TAG_W-1:0] tag_mem [ENTRIES];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] arch_q, arch_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] spec_q, spec_d;
    logic             error_q, error_d;

    logic [NUM_W-1:0] grant;
    logic [NUM_W-1:0] free_eff;
    logic [NUM_W-1:0] commit_eff;
    logic             overflow;
    logic             commit_err;

    logic [SUM_W-1:0] count_w, spec_w, free_w, commit_w, grant_w, avail_w;

    logic [PTR_W-1:0] rd_idx [WAYS];
    logic [PTR_W-1:0] wr_idx [WAYS];
    logic [PTR_W-1:0] head_adv, tail_adv, arch_adv;

    // Grant, protocol checks and the effective free/commit amounts.
    always_comb begin
        count_w  = SUM_W'(count_q);
        spec_w   = SUM_W'(spec_q);
        free_w   = SUM_W'(free_num);
        commit_w = SUM_W'(commit_num);

        grant = '0;
        if (!reset && !recover) begin
            grant = NUM_W'(min_u(32'(alloc_num), 32'(count_q)));
        end
        grant_w = SUM_W'(grant);

        overflow   = (count_w + free_w) > SUM_W'(ENTRIES);
        avail_w    = spec_w + grant_w;
        commit_err = commit_w > avail_w;
        commit_eff = commit_err ? NUM_W'(avail_w) : commit_num;
        free_eff   = overflow ? '0 : free_num;
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_lane
        fl_ptr_add #(
            .ENTRIES(ENTRIES),
            .PTR_W  (PTR_W),
            .N_W    (NUM_W)
        ) u_rd (
            .ptr(head_q),
            .n  (NUM_W'(g)),
            .sum(rd_idx[g])
        );

        fl_ptr_add #(
            .ENTRIES(ENTRIES),
            .PTR_W  (PTR_W),
            .N_W    (NUM_W)
        ) u_wr (
            .ptr(tail_q),
            .n  (NUM_W'(g)),
            .sum(wr_idx[g])
        );
    end

    fl_ptr_add #(
        .ENTRIES(ENTRIES),
        .PTR_W  (PTR_W),
        .N_W    (NUM_W)
    ) u_head (
        .ptr(head_q),
        .n  (grant),
        .sum(head_adv)
    );

    fl_ptr_add #(
        .ENTRIES(ENTRIES),
        .PTR_W  (PTR_W),
        .N_W    (NUM_W)
    ) u_tail (
        .ptr(tail_q),
        .n  (free_eff),
        .sum(tail_adv)
    );

    fl_ptr_add #(
        .ENTRIES(ENTRIES),
        .PTR_W  (PTR_W),
        .N_W    (NUM_W)
    ) u_arch (
        .ptr(arch_q),
        .n  (commit_eff),
        .sum(arch_adv)
    );

    // Next-state for pointers and counters.
    always_comb begin
        tail_d  = tail_adv;
        arch_d  = arch_adv;
        error_d = error_q | overflow | commit_err;

        if (recover) begin
            // Uncommitted allocations rejoin the free region in front of the old head.
            head_d  = arch_adv;
            count_d = CNT_W'(count_w + SUM_W'(free_eff) + spec_w - SUM_W'(commit_eff));
            spec_d  = '0;
        end else begin
            head_d  = head_adv;
            count_d = CNT_W'(count_w - grant_w + SUM_W'(free_eff));
            spec_d  = CNT_W'(spec_w + grant_w - SUM_W'(commit_eff));
        end

        if (overflow) begin
            count_d = CNT_W'(ENTRIES);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            arch_q  <= '0;
            count_q <= CNT_W'(ENTRIES);
            spec_q  <= '0;
            error_q <= 1'b0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_mem[i] <= TAG_W'(ARF_SIZE + i);
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            arch_q  <= arch_d;
            count_q <= count_d;
            spec_q  <= spec_d;
            error_q <= error_d;
            for (int i = 0; i < int'(WAYS); i++) begin
                if (NUM_W'(i) < free_eff) begin
                    tag_mem[wr_idx[i]] <= free_tag[i*TAG_W +: TAG_W];
                end
            end
        end
    end

    always_comb begin
        alloc_tag   = '0;
        alloc_valid = '0;
        for (int i = 0; i < int'(WAYS); i++) begin
            if (NUM_W'(i) < grant) begin
                alloc_valid[i]              = 1'b1;
                alloc_tag[i*TAG_W +: TAG_W] = tag_mem[rd_idx[i]];
            end
        end
    end

    assign free_count = count_q;
    assign error      = error_q;

endmodule

// File: tb/tb_free_list_n.sv
// Bench for free_list_n: directed scenarios plus random traffic against a queue-based model.
module tb_free_list_n;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Default-sized instance.
    logic        a_rst;
    logic [1:0]  a_alloc, a_free, a_commit;
    logic [13:0] a_ftag;
    logic        a_rec;
    logic [13:0] a_atag;
    logic [1:0]  a_av;
    logic [6:0]  a_fc;
    logic        a_err;

    // Small instance with ENTRIES = 5.
    logic        b_rst;
    logic [1:0]  b_alloc, b_free, b_commit;
    logic [11:0] b_ftag;
    logic        b_rec;
    logic [11:0] b_atag;
    logic [1:0]  b_av;
    logic [2:0]  b_fc;
    logic        b_err;

    free_list_n u_dut_a (
        .clock      (clock),
        .reset      (a_rst),
        .alloc_num  (a_alloc),
        .free_num   (a_free),
        .free_tag   (a_ftag),
        .commit_num (a_commit),
        .recover    (a_rec),
        .alloc_tag  (a_atag),
        .alloc_valid(a_av),
        .free_count (a_fc),
        .error      (a_err)
    );

    free_list_n #(
        .PRF_SIZE(37),
        .ARF_SIZE(32),
        .WAYS    (2)
    ) u_dut_b (
        .clock      (clock),
        .reset      (b_rst),
        .alloc_num  (b_alloc),
        .free_num   (b_free),
        .free_tag   (b_ftag),
        .commit_num (b_commit),
        .recover    (b_rec),
        .alloc_tag  (b_atag),
        .alloc_valid(b_av),
        .free_count (b_fc),
        .error      (b_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: free FIFO, speculative allocations in order, and the pool of live mapped tags.
    int fq[$];
    int sq[$];
    int pool[$];
    bit m_err;
    int p_alloc, p_free, p_commit, p_grant, p_ft0, p_ft1;
    bit p_rec;

    task automatic model_reset();
        fq.delete();
        sq.delete();
        pool.delete();
        for (int i = 0; i < 64; i++) fq.push_back(32 + i);
        for (int i = 0; i < 32; i++) pool.push_back(i);
        m_err = 1'b0;
    endtask

    task automatic a_idle();
        a_alloc  = '0;
        a_free   = '0;
        a_commit = '0;
        a_rec    = 1'b0;
        a_ftag   = '0;
    endtask

    task automatic a_reset();
        a_rst   = 1'b1;
        a_idle();
        a_alloc = 2'd2;
        a_rec   = 1'b1;
        @(posedge clock); #1;
        check("reset_av", 32'(a_av), 0);
        @(posedge clock); #1;
        a_rst = 1'b0;
        a_idle();
        model_reset();
        #1;
        check("reset_fc", 32'(a_fc), 64);
        check("reset_err", 32'(a_err), 0);
        check("reset_idle_av", 32'(a_av), 0);
    endtask

    task automatic a_drive(input int alloc, input int free, input int commit, input bit rec,
                           input int ft0, input int ft1);
        logic [13:0] et;
        logic [1:0]  ev;
        p_alloc  = alloc;
        p_free   = free;
        p_commit = commit;
        p_rec    = rec;
        p_ft0    = ft0;
        p_ft1    = ft1;
        p_grant  = rec ? 0 : ((alloc < fq.size()) ? alloc : fq.size());
        a_alloc  = 2'(alloc);
        a_free   = 2'(free);
        a_commit = 2'(commit);
        a_rec    = rec;
        a_ftag   = {7'(ft1), 7'(ft0)};
        #1;
        et = '0;
        ev = '0;
        for (int k = 0; k < p_grant; k++) begin
            et[k*7 +: 7] = 7'(fq[k]);
            ev[k]        = 1'b1;
        end
        check("alloc_valid", 32'(a_av), 32'(ev));
        check("alloc_tag", 32'(a_atag), 32'(et));
    endtask

    task automatic a_step();
        int cnt;
        cnt = fq.size();
        if (cnt + p_free > 64) m_err = 1'b1;
        if (p_commit > sq.size() + p_grant) m_err = 1'b1;
        for (int k = 0; k < p_grant; k++) sq.push_back(fq.pop_front());
        for (int k = 0; k < p_commit; k++) if (sq.size() > 0) pool.push_back(sq.pop_front());
        if (p_rec) while (sq.size() > 0) fq.push_front(sq.pop_back());
        if (cnt + p_free <= 64) begin
            if (p_free > 0) fq.push_back(p_ft0);
            if (p_free > 1) fq.push_back(p_ft1);
        end
        @(posedge clock); #1;
        check("free_count", 32'(a_fc), 32'(fq.size()));
        check("error", 32'(a_err), 32'(m_err));
    endtask

    initial begin
        int bq[$];
        int pv0, pv1, g0, g1;

        b_rst    = 1'b1;
        b_alloc  = '0;
        b_free   = '0;
        b_commit = '0;
        b_rec    = 1'b0;
        b_ftag   = '0;

        // First grants after reset come from the top of the free region in order.
        a_reset();
        a_drive(2, 0, 0, 0, 0, 0);
        check("first_tags", 32'(a_atag), 32'({7'd33, 7'd32}));
        a_step();
        check("fc_62", 32'(a_fc), 62);
        a_drive(2, 0, 0, 0, 0, 0);
        check("second_tags", 32'(a_atag), 32'({7'd35, 7'd34}));
        a_step();
        check("fc_60", 32'(a_fc), 60);

        // Partial grant with one left, then an empty list.
        a_reset();
        for (int c = 0; c < 31; c++) begin
            a_drive(2, 0, 0, 0, 0, 0);
            a_step();
        end
        a_drive(1, 0, 0, 0, 0, 0);
        a_step();
        check("fc_one", 32'(a_fc), 1);
        a_drive(2, 0, 0, 0, 0, 0);
        check("partial_av", 32'(a_av), 1);
        check("partial_tag", 32'(a_atag), 95);
        a_step();
        check("fc_zero", 32'(a_fc), 0);
        a_drive(2, 0, 0, 0, 0, 0);
        check("empty_av", 32'(a_av), 0);
        a_step();
        check("empty_err", 32'(a_err), 0);

        // Freed tags are not forwarded to same-cycle allocations.
        a_drive(2, 2, 0, 0, 40, 41);
        check("nofwd_av", 32'(a_av), 0);
        a_step();
        check("nofwd_fc", 32'(a_fc), 2);
        a_drive(2, 0, 0, 0, 0, 0);
        check("freed_tags", 32'(a_atag), 32'({7'd41, 7'd40}));
        check("freed_av", 32'(a_av), 3);
        a_step();

        // Recover with a same-cycle commit.
        a_reset();
        for (int c = 0; c < 3; c++) begin
            a_drive(2, 0, 0, 0, 0, 0);
            a_step();
        end
        a_drive(0, 0, 2, 0, 0, 0);
        a_step();
        a_drive(0, 0, 1, 1, 0, 0);
        check("recover_av", 32'(a_av), 0);
        a_step();
        check("recover_fc", 32'(a_fc), 61);
        a_drive(1, 0, 0, 0, 0, 0);
        check("recover_tag", 32'(a_atag), 35);
        a_step();

        // Freeing into a full list is an overflow.
        a_reset();
        a_drive(0, 1, 0, 0, 5, 0);
        a_step();
        check("ovf_err", 32'(a_err), 1);
        check("ovf_fc", 32'(a_fc), 64);
        a_drive(0, 0, 0, 0, 0, 0);
        a_step();
        check("ovf_sticky", 32'(a_err), 1);
        a_reset();

        // Random legal traffic.
        for (int c = 0; c < 400; c++) begin
            int alloc, free, commit, grant, maxc, maxf, idx;
            int ft[2];
            bit rec;
            rec    = ($urandom_range(0, 15) == 0);
            alloc  = $urandom_range(0, 2);
            grant  = rec ? 0 : ((alloc < fq.size()) ? alloc : fq.size());
            maxc   = rec ? sq.size() : sq.size() + grant;
            if (maxc > 2) maxc = 2;
            commit = $urandom_range(0, maxc);
            maxf   = pool.size() - 32;
            if (maxf > 2) maxf = 2;
            free   = $urandom_range(0, maxf);
            ft[0]  = 0;
            ft[1]  = 0;
            for (int k = 0; k < free; k++) begin
                idx   = $urandom_range(0, pool.size() - 1);
                ft[k] = pool[idx];
                pool.delete(idx);
            end
            a_drive(alloc, free, commit, rec, ft[0], ft[1]);
            a_step();
        end
        a_idle();

        // Non-power-of-two depth: steady alloc/free of two per cycle wraps the pointers.
        @(posedge clock); #1;
        @(posedge clock); #1;
        b_rst = 1'b0;
        #1;
        check("b_reset_fc", 32'(b_fc), 5);
        for (int i = 0; i < 5; i++) bq.push_back(32 + i);
        pv0 = 0;
        pv1 = 0;
        for (int c = 0; c < 20; c++) begin
            b_alloc  = 2'd2;
            b_commit = 2'd2;
            b_rec    = 1'b0;
            b_free   = (c == 0) ? 2'd0 : 2'd2;
            b_ftag   = {6'(pv1), 6'(pv0)};
            #1;
            check("b_av", 32'(b_av), 3);
            check("b_tags", 32'(b_atag), 32'({6'(bq[1]), 6'(bq[0])}));
            g0 = bq.pop_front();
            g1 = bq.pop_front();
            if (c > 0) begin
                bq.push_back(pv0);
                bq.push_back(pv1);
            end
            pv0 = g0;
            pv1 = g1;
            @(posedge clock); #1;
            check("b_fc", 32'(b_fc), 32'(bq.size()));
            check("b_err", 32'(b_err), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/free_list_n.md
FREE_LIST_N -- requirements
Module: free_list_n

Interface
REQ-001 SHALL have parameter PRF_SIZE, default 96: total physical registers.
REQ-002 SHALL have parameter ARF_SIZE, default 32: architectural registers, i.e. tags 0..ARF_SIZE-1 mapped at reset.
REQ-003 SHALL have parameter WAYS, default 2: maximum allocations, frees and commits per cycle.
REQ-004 SHALL derive TAG_W = clog2(PRF_SIZE), ENTRIES = PRF_SIZE-ARF_SIZE, NUM_W = clog2(WAYS+1), CNT_W = clog2(ENTRIES+1).
REQ-005 SHALL have port clock, input, 1: clock, all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port alloc_num, input, NUM_W: tags requested by dispatch this cycle (0..WAYS).
REQ-008 SHALL have port free_num, input, NUM_W: tags returned by retire this cycle (0..WAYS).
REQ-009 SHALL have port free_tag, input, WAYS*TAG_W: returned tags, lane 0 in the low bits.
REQ-010 SHALL have port commit_num, input, NUM_W: speculative allocations made architectural this cycle.
REQ-011 SHALL have port recover, input, 1: mispredict flush that reclaims all uncommitted allocations.
REQ-012 SHALL have port alloc_tag, output, WAYS*TAG_W: granted tags, lane 0 in the low bits.
REQ-013 SHALL have port alloc_valid, output, WAYS: per-lane grant.
REQ-014 SHALL have port free_count, output, CNT_W: registered count of free tags.
REQ-015 SHALL have port error, output, 1: sticky protocol error.

Function
REQ-016 SHALL store tags in an ENTRIES-deep circular buffer with head (read), tail (write), arch_head, count and spec_cnt registers; pointers wrap ENTRIES-1 -> 0 at any ENTRIES, including non-powers of two.
REQ-017 SHALL compute grant = min(alloc_num, count) combinationally, forced to 0 while recover is high.
REQ-018 SHALL drive alloc_tag lane i = buf[(head+i) mod ENTRIES] and alloc_valid[i] = (i < grant); lanes not granted output tag 0.
REQ-019 SHALL write free_tag lane i to buf[(tail+i) mod ENTRIES] for each i < free_num, then advance tail by free_num.
REQ-020 SHALL NOT forward tags freed in a cycle to allocations in that same cycle; freed tags become allocatable the next cycle.
REQ-021 SHALL advance head by grant, arch_head by commit_num, and set spec_cnt_next = spec_cnt + grant - commit_num.
REQ-022 SHALL set count_next = count - grant + free_num.
REQ-023 SHALL on recover set head_next = arch_head + commit_num (mod ENTRIES), count_next = count + free_num + (spec_cnt - commit_num), and spec_cnt_next = 0; free and commit in the same cycle SHALL still take effect.
REQ-024 SHALL set error when count + free_num exceeds ENTRIES (overflow) or commit_num exceeds spec_cnt + grant; on overflow the write SHALL be dropped and count saturated at ENTRIES.
REQ-025 SHALL take alloc_num > count as a legal partial grant, not an error.

Reset
REQ-026 SHALL on reset load buf[i] = ARF_SIZE+i, head = tail = arch_head = 0, count = ENTRIES, spec_cnt = 0 and error = 0.
REQ-027 SHALL let reset override all inputs, including mid-recover, and leave outputs all-zero-valid except for the buffer contents.

Structure
REQ-028 SHALL place PRF_SIZE, ARF_SIZE, WAYS defaults and the tag type in the shared core package.
REQ-029 SHALL use one sub-module, fl_ptr_add, for modular pointer add (ptr + n mod ENTRIES).

Verification
REQ-030 SHALL cover: after reset, alloc_num=2 -> tags 32,33 valid; next cycle alloc_num=2 -> 34,35; free_count 64 -> 62 -> 60.
REQ-031 SHALL cover: with count=1, alloc_num=2 -> alloc_valid=01 and free_count becomes 0; with count=0, alloc_num=2 -> alloc_valid=00 and error stays 0.
REQ-032 SHALL cover: drain all 64 tags, free 40,41 (free_num=2) while alloc_num=2 -> no grant that cycle; next cycle the grant is 40,41.
REQ-033 SHALL cover: allocate 6 tags, commit 2, then recover with commit_num=1 -> free_count returns to 61 and the next allocation yields tag 35.
REQ-034 SHALL cover: at reset state, free_num=1 -> error=1 and free_count remains 64 until reset.
REQ-035 SHALL cover: with ENTRIES=5 (PRF_SIZE=37), repeated alloc/free of 2 per cycle for 20 cycles -> pointers wrap and tags return in FIFO order.
